// File: rtl/shifter_sweep_ctrl.sv
// Time-shares one pipelined barrel shifter between NREQ requesters. Each granted
// request sweeps COUNT consecutive select values and returns one result per select.
module shifter_sweep_ctrl #(
    parameter int SIZE      = 64,
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 2,
    parameter int SHIFT_LAT = 1,
    parameter int STAGES    = $clog2(SIZE),
    parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [NREQ*SIZE*DATAWIDTH-1:0]    req_data,
    input  logic [NREQ*STAGES-1:0]            req_shift,
    input  logic [NREQ*(STAGES+1)-1:0]        req_count,
    output logic [SIZE*DATAWIDTH-1:0]         sh_inarray,
    output logic [STAGES-1:0]                 sh_select,
    input  logic [SIZE*DATAWIDTH-1:0]         sh_outarray,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SIZE*DATAWIDTH-1:0]         out_data,
    output logic [IDW-1:0]                    out_id,
    output logic [STAGES-1:0]                 out_shift,
    output logic                              out_last,
    output logic [1:0]                        dbg_state
);
    localparam int AW   = SIZE * DATAWIDTH;
    localparam int CW   = STAGES + 1;
    localparam int LATW = (SHIFT_LAT < 1) ? 1 : $clog2(SHIFT_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state, w_next;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [CW-1:0]       r_remaining;
    logic [LATW-1:0]     r_wait;
    logic [AW-1:0]       r_inarray;
    logic [STAGES-1:0]   r_sel;
    logic [AW-1:0]       r_odata;
    logic                r_ovalid;
    logic                r_olast;

    logic [IDW-1:0]      w_grant;
    logic                w_found;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_count_eff;
    logic [STAGES-1:0]   w_sel_next;
    logic [IDW-1:0]      w_ptr_next;
    logic                w_more;

    // Round-robin search starting at the pointer, wrapping at NREQ.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_grant = IDW'((int'(r_ptr) + k) % NREQ);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_found) req_ready[w_grant] = 1'b1;
    end

    assign w_count     = req_count[int'(w_grant)*CW +: CW];
    assign w_count_eff = (w_count == '0) ? CW'(1) : w_count;
    assign w_sel_next  = (r_sel == STAGES'(SIZE - 1)) ? '0 : r_sel + STAGES'(1);
    assign w_ptr_next  = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
    assign w_more      = (r_remaining > CW'(1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_WAIT;
            S_WAIT:  if (r_wait == '0) w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = w_more ? S_WAIT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_remaining <= '0;
            r_wait      <= '0;
            r_inarray   <= '0;
            r_sel       <= '0;
            r_odata     <= '0;
            r_ovalid    <= 1'b0;
            r_olast     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_inarray   <= req_data[int'(w_grant)*AW +: AW];
                        r_sel       <= req_shift[int'(w_grant)*STAGES +: STAGES];
                        r_remaining <= w_count_eff;
                        r_id        <= w_grant;
                        r_wait      <= LATW'(SHIFT_LAT);
                    end
                end
                S_WAIT: begin
                    // Counter reaching zero means the shifter output now reflects r_sel.
                    if (r_wait == '0) begin
                        r_odata  <= sh_outarray;
                        r_ovalid <= 1'b1;
                        r_olast  <= (r_remaining == CW'(1));
                    end else begin
                        r_wait <= r_wait - LATW'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_ovalid <= 1'b0;
                        if (w_more) begin
                            r_sel       <= w_sel_next;
                            r_remaining <= r_remaining - CW'(1);
                            r_wait      <= LATW'(SHIFT_LAT);
                        end else begin
                            r_olast <= 1'b0;
                            r_ptr   <= w_ptr_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sh_inarray = r_inarray;
    assign sh_select  = r_sel;
    assign out_shift  = r_sel;
    assign out_data   = r_odata;
    assign out_valid  = r_ovalid;
    assign out_last   = r_olast;
    assign out_id     = r_id;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_shifter_sweep_ctrl.sv
// Bench for shifter_sweep_ctrl: a rotate-register shifter model, a request-level
// expected-output model with a per-cycle compare process, and directed scenarios.
module tb_shifter_sweep_ctrl;
    localparam int SIZE = 64;
    localparam int DW   = 8;
    localparam int NREQ = 2;
    localparam int ST   = 6;
    localparam int CW   = ST + 1;
    localparam int W    = SIZE * DW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_data = '0;
    logic [NREQ*ST-1:0]   req_shift = '0;
    logic [NREQ*CW-1:0]   req_count = '0;
    logic [W-1:0]         sh_inarray;
    logic [ST-1:0]        sh_select;
    logic [W-1:0]         sh_outarray;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [W-1:0]         out_data;
    logic [0:0]           out_id;
    logic [ST-1:0]        out_shift;
    logic                 out_last;
    logic [1:0]           dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int evt_cyc = 0;
    int m_ptr = 0;
    bit busy = 1'b0;
    bit prev_valid = 1'b0;

    logic [W-1:0]  exp_q[$];
    logic [ST-1:0] exp_sh_q[$];
    int            exp_id_q[$];
    bit            exp_last_q[$];
    logic [W-1:0]  exp_in;
    int            id_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    shifter_sweep_ctrl #(
        .SIZE(SIZE), .DATAWIDTH(DW), .NREQ(NREQ), .SHIFT_LAT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift), .req_count(req_count),
        .sh_inarray(sh_inarray), .sh_select(sh_select), .sh_outarray(sh_outarray),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_shift(out_shift), .out_last(out_last),
        .dbg_state(dbg_state)
    );

    function automatic logic [W-1:0] rot(logic [W-1:0] d, int s);
        logic [W-1:0] r;
        for (int k = 0; k < SIZE; k++) r[k*DW +: DW] = d[((k + s) % SIZE)*DW +: DW];
        return r;
    endfunction

    function automatic logic [W-1:0] mkdata(int base);
        logic [W-1:0] d;
        for (int j = 0; j < SIZE; j++) d[j*DW +: DW] = DW'((base + j) % 256);
        return d;
    endfunction

    // One-register rotating shifter
    always @(posedge clk) sh_outarray <= rot(sh_inarray, int'(sh_select));

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // Per-cycle compare against the request-level model
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        int s;
        int c;
        if (rst) begin
            exp_q.delete(); exp_sh_q.delete(); exp_id_q.delete(); exp_last_q.delete();
            busy = 1'b0;
            m_ptr = 0;
            prev_valid = 1'b0;
        end else begin
            exp_rdy = '0;
            g = -1;
            if (!busy)
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", W'(req_ready), W'(exp_rdy));
            if (out_valid && !prev_valid) chk("rise_cycle", W'(cyc), W'(evt_cyc + 2));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_out_valid");
                end else begin
                    chk("out_data",   out_data,           exp_q[0]);
                    chk("out_shift",  W'(out_shift),      W'(exp_sh_q[0]));
                    chk("sh_select",  W'(sh_select),      W'(exp_sh_q[0]));
                    chk("out_id",     W'(out_id),         W'(exp_id_q[0]));
                    chk("out_last",   W'(out_last),       W'(exp_last_q[0]));
                    chk("sh_inarray", sh_inarray,         exp_in);
                    if (out_ready) begin
                        hs_cnt++;
                        id_log.push_back(int'(out_id));
                        evt_cyc = cyc + 1;
                        if (exp_last_q[0]) begin
                            busy = 1'b0;
                            m_ptr = (exp_id_q[0] + 1) % NREQ;
                        end
                        void'(exp_q.pop_front());
                        void'(exp_sh_q.pop_front());
                        void'(exp_id_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
            if (g >= 0) begin
                s = int'(req_shift[g*ST +: ST]);
                c = int'(req_count[g*CW +: CW]);
                if (c == 0) c = 1;
                exp_in = req_data[g*W +: W];
                for (int j = 0; j < c; j++) begin
                    exp_q.push_back(rot(exp_in, (s + j) % SIZE));
                    exp_sh_q.push_back(ST'((s + j) % SIZE));
                    exp_id_q.push_back(g);
                    exp_last_q.push_back(j == c - 1);
                end
                busy = 1'b1;
                evt_cyc = cyc + 1;
            end
        end
    end

    task automatic issue(int i, logic [W-1:0] d, int s, int c);
        bit ok;
        @(posedge clk);
        #1;
        req_data[i*W +: W]    = d;
        req_shift[i*ST +: ST] = ST'(s);
        req_count[i*CW +: CW] = CW'(c);
        req_valid[i]          = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready[i];
        end
        if (!ok) begin
            timeout_fail("accept_wait");
            req_valid[i] = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_valid[i] = 1'b0;
        end
    endtask

    task automatic wait_valid(string name, output int t);
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) timeout_fail(name);
    endtask

    task automatic wait_idle(string name);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (busy || exp_q.size() != 0) timeout_fail(name);
        @(negedge clk);
    endtask

    initial begin
        int t;
        int base;
        bit hit;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",  W'(out_valid), W'(0));
        chk("rst_sh_select",  W'(sh_select), W'(0));
        chk("rst_sh_inarray", sh_inarray,    W'(0));
        chk("rst_out_data",   out_data,      W'(0));
        chk("rst_out_last",   W'(out_last),  W'(0));
        chk("rst_req_ready",  W'(req_ready), W'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // 1: single shift
        base = hs_cnt;
        issue(0, mkdata(0), 5, 1);
        wait_valid("t1_valid", t);
        chk("t1_latency",   W'(t),                 W'(3));
        chk("t1_elem0",     W'(out_data[7:0]),     W'(5));
        chk("t1_elem63",    W'(out_data[511:504]), W'(4));
        chk("t1_out_shift", W'(out_shift),         W'(5));
        chk("t1_out_id",    W'(out_id),            W'(0));
        chk("t1_out_last",  W'(out_last),          W'(1));
        @(negedge clk);
        chk("t1_valid_drop", W'(out_valid), W'(0));
        wait_idle("t1_idle");
        chk("t1_outputs", W'(hs_cnt - base), W'(1));

        // 2: wrapping sweep from 62
        base = hs_cnt;
        issue(1, mkdata(0), 62, 4);
        wait_valid("t2_valid", t);
        chk("t2_first_shift", W'(out_shift),      W'(62));
        chk("t2_elem0",       W'(out_data[7:0]),  W'(62));
        chk("t2_elem5",       W'(out_data[47:40]), W'(3));
        wait_idle("t2_idle");
        chk("t2_outputs", W'(hs_cnt - base), W'(4));

        // 3: contention, two rounds
        id_log.delete();
        fork
            issue(0, mkdata(0), 1, 1);
            issue(1, mkdata(100), 2, 1);
        join
        wait_idle("t3a_idle");
        fork
            issue(0, mkdata(0), 3, 1);
            issue(1, mkdata(100), 4, 1);
        join
        wait_idle("t3b_idle");
        chk("t3_grants", W'(id_log.size()), W'(4));
        if (id_log.size() == 4) begin
            chk("t3_order0", W'(id_log[0]), W'(0));
            chk("t3_order1", W'(id_log[1]), W'(1));
            chk("t3_order2", W'(id_log[2]), W'(0));
            chk("t3_order3", W'(id_log[3]), W'(1));
        end

        // 4: backpressure during a count=3 sweep
        base = hs_cnt;
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(0, mkdata(3), 20, 3);
        wait_valid("t4_valid", t);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_hold_valid",  W'(out_valid),     W'(1));
            chk("t4_hold_select", W'(sh_select),     W'(20));
            chk("t4_hold_elem0",  W'(out_data[7:0]), W'(23));
            chk("t4_hold_ready",  W'(req_ready),     W'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle("t4_idle");
        chk("t4_outputs", W'(hs_cnt - base), W'(3));

        // 5: full sweep interrupted by reset after the 3rd handshake
        base = hs_cnt;
        issue(0, mkdata(0), 0, 64);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(posedge clk);
            hit = (hs_cnt >= base + 3);
        end
        if (!hit) timeout_fail("t5_third_handshake");
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid",  W'(out_valid), W'(0));
        chk("t5_rst_select", W'(sh_select), W'(0));
        chk("t5_rst_last",   W'(out_last),  W'(0));
        issue(1, mkdata(0), 7, 1);
        wait_valid("t5_valid", t);
        chk("t5_out_shift", W'(out_shift), W'(7));
        chk("t5_out_id",    W'(out_id),    W'(1));
        wait_idle("t5_idle");

        // 6: count 0 behaves as count 1
        base = hs_cnt;
        issue(0, mkdata(9), 10, 0);
        wait_valid("t6_valid", t);
        chk("t6_out_shift", W'(out_shift), W'(10));
        chk("t6_out_last",  W'(out_last),  W'(1));
        wait_idle("t6_idle");
        chk("t6_outputs", W'(hs_cnt - base), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
